// File: rtl/regfile_access_arbiter_pkg.sv
// Shared types and helpers for the register-file access arbiter.
// Optional feature macro used by the top level: RFARB_PERF_CNT_EN.
package regfile_arb_pkg;

   // Debug request opcodes; the reserved encoding 2'b11 is folded into OP_READ on accept
   typedef enum logic [1:0] {
      OP_READ  = 2'b00,
      OP_WRITE = 2'b01,
      OP_CLEAR = 2'b10
   } dbg_op_e;

   // Arbiter control states
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PEND,
      ST_CLEAR,
      ST_STALL,
      ST_RESP
   } arb_state_e;

   // Address of the hard-wired zero register (always the last register)
   function automatic int unsigned xzr_addr(input int unsigned reg_count,
                                            input int unsigned reg_addr_width);
      return (reg_count - 1) & ((32'd1 << reg_addr_width) - 32'd1);
   endfunction

endpackage

// File: rtl/regfile_access_arbiter_if.sv
// Debug host request/response bundle for the register-file access arbiter.
interface regfile_access_arbiter_if #(
   parameter int DATA_WIDTH     = 32,
   parameter int REG_ADDR_WIDTH = 5
);
   logic                      dbg_req_valid_in;
   logic                      dbg_req_ready_out;
   logic [1:0]                dbg_req_op_in;
   logic [REG_ADDR_WIDTH-1:0] dbg_req_addr_in;
   logic [DATA_WIDTH-1:0]     dbg_req_data_in;
   logic                      dbg_rsp_valid_out;
   logic [DATA_WIDTH-1:0]     dbg_rsp_data_out;

   modport master (
      output dbg_req_valid_in, dbg_req_op_in, dbg_req_addr_in, dbg_req_data_in,
      input  dbg_req_ready_out, dbg_rsp_valid_out, dbg_rsp_data_out
   );

   modport slave (
      input  dbg_req_valid_in, dbg_req_op_in, dbg_req_addr_in, dbg_req_data_in,
      output dbg_req_ready_out, dbg_rsp_valid_out, dbg_rsp_data_out
   );
endinterface

// File: rtl/regfile_access_arbiter_starve_timer.sv
// Counts cycles a pending debug access has been blocked by the core and
// flags when the next blocked cycle must become a forced core stall.
module rfarb_starve_timer #(
   parameter int STARVE_LIMIT = 8
) (
   input  logic clk,
   input  logic rst_n,
   input  logic inc,
   input  logic clr,
   output logic limit_hit
);
   localparam logic [7:0] HIT_VALUE = 8'(STARVE_LIMIT - 1);

   logic [7:0] r_wait_cnt;

   // Blocked-cycle counter; clear wins over increment, and it never wraps
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wait_cnt <= '0;
      end else if (clr) begin
         r_wait_cnt <= '0;
      end else if (inc && (r_wait_cnt != 8'hFF)) begin
         r_wait_cnt <= r_wait_cnt + 8'd1;
      end
   end

   // High on the blocked cycle that brings the count up to the limit
   assign limit_hit = (r_wait_cnt >= HIT_VALUE);

endmodule

// File: rtl/regfile_access_arbiter.sv
// Shares the register file write port and read port 2 between the core
// (priority) and the debug host; also sequences a debug clear-all.
// Optional macro RFARB_PERF_CNT_EN adds debug-access and stall counters.
module regfile_access_arbiter
   import regfile_arb_pkg::*;
#(
   parameter int DATA_WIDTH     = 32,
   parameter int REG_COUNT      = 32,
   parameter int REG_ADDR_WIDTH = 5,
   parameter int STARVE_LIMIT   = 8
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      core_wr_en_in,
   input  logic [REG_ADDR_WIDTH-1:0] core_wr_addr_in,
   input  logic [DATA_WIDTH-1:0]     core_wr_data_in,
   input  logic                      core_rd2_busy_in,
   input  logic [REG_ADDR_WIDTH-1:0] core_rd2_addr_in,
   output logic                      core_stall_out,
   regfile_access_arbiter_if.slave   dbg,
`ifdef RFARB_PERF_CNT_EN
   output logic [31:0]               dbg_access_cnt_out,
   output logic [31:0]               stall_cnt_out,
`endif
   output logic                      rf_write_en_out,
   output logic [REG_ADDR_WIDTH-1:0] rf_write_addr_out,
   output logic [DATA_WIDTH-1:0]     rf_write_data_out,
   output logic [REG_ADDR_WIDTH-1:0] rf_read_addr2_out,
   input  logic [DATA_WIDTH-1:0]     rf_read_data2_in
);
   localparam logic [REG_ADDR_WIDTH-1:0] XZR =
      REG_ADDR_WIDTH'(xzr_addr(REG_COUNT, REG_ADDR_WIDTH));
   localparam logic [REG_ADDR_WIDTH-1:0] LAST_CLEAR = XZR - 1'b1;

   arb_state_e                r_state;
   arb_state_e                w_next;
   dbg_op_e                   r_op;
   logic [REG_ADDR_WIDTH-1:0] r_addr;
   logic [DATA_WIDTH-1:0]     r_data;
   logic [REG_ADDR_WIDTH-1:0] r_clear_idx;
   logic                      r_stall;
   logic                      r_rsp_valid;
   logic [DATA_WIDTH-1:0]     r_rsp_data;

   logic w_accept;
   logic w_slot_free;
   logic w_clear_free;
   logic w_last;
   logic w_access;
   logic w_dbg_wr_en;
   logic w_inc;
   logic w_clr;
   logic w_limit_hit;

   // A read also needs read port 2, so core use of it blocks reads but not writes
   assign w_accept     = (r_state == ST_IDLE) && dbg.dbg_req_valid_in;
   assign w_slot_free  = !core_wr_en_in && ((r_op == OP_WRITE) || !core_rd2_busy_in);
   assign w_clear_free = !core_wr_en_in;
   assign w_last       = (r_clear_idx == LAST_CLEAR);
   assign w_access     = ((r_state == ST_PEND)  && w_slot_free)  ||
                         (r_state == ST_STALL)                   ||
                         ((r_state == ST_CLEAR) && w_clear_free);
   assign w_dbg_wr_en  = (r_op == OP_CLEAR) || ((r_op == OP_WRITE) && (r_addr != XZR));
   assign w_inc        = ((r_state == ST_PEND)  && !w_slot_free) ||
                         ((r_state == ST_CLEAR) && !w_clear_free);
   assign w_clr        = w_access || (r_state == ST_RESP);

   rfarb_starve_timer #(
      .STARVE_LIMIT (STARVE_LIMIT)
   ) u_starve_timer (
      .clk       (clk),
      .rst_n     (rst_n),
      .inc       (w_inc),
      .clr       (w_clr),
      .limit_hit (w_limit_hit)
   );

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state logic: serve in free slots, force a stall once starved
   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
               w_next = (dbg.dbg_req_op_in == 2'b10) ? ST_CLEAR : ST_PEND;
            end
         end
         ST_PEND: begin
            if (w_slot_free) begin
               w_next = ST_RESP;
            end else if (w_limit_hit) begin
               w_next = ST_STALL;
            end
         end
         ST_CLEAR: begin
            if (w_clear_free) begin
               w_next = w_last ? ST_RESP : ST_CLEAR;
            end else if (w_limit_hit) begin
               w_next = ST_STALL;
            end
         end
         ST_STALL: begin
            if (r_op == OP_CLEAR) begin
               w_next = w_last ? ST_RESP : ST_CLEAR;
            end else begin
               w_next = ST_RESP;
            end
         end
         ST_RESP: begin
            w_next = ST_IDLE;
         end
         default: begin
            w_next = ST_IDLE;
         end
      endcase
   end

   // Port muxing: debug owns the ports only in its access cycle, core otherwise
   always_comb begin
      rf_write_en_out   = core_wr_en_in;
      rf_write_addr_out = core_wr_addr_in;
      rf_write_data_out = core_wr_data_in;
      rf_read_addr2_out = core_rd2_addr_in;
      if (w_access) begin
         rf_write_en_out = w_dbg_wr_en;
         if (r_op == OP_CLEAR) begin
            rf_write_addr_out = r_clear_idx;
            rf_write_data_out = '0;
            rf_read_addr2_out = r_clear_idx;
         end else begin
            rf_write_addr_out = r_addr;
            rf_write_data_out = r_data;
            rf_read_addr2_out = r_addr;
         end
      end
   end

   // Request capture on handshake, and clear-all address stepping
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_op        <= OP_READ;
         r_addr      <= '0;
         r_data      <= '0;
         r_clear_idx <= '0;
      end else if (w_accept) begin
         case (dbg.dbg_req_op_in)
            2'b01:   r_op <= OP_WRITE;
            2'b10:   r_op <= OP_CLEAR;
            default: r_op <= OP_READ;
         endcase
         r_addr      <= dbg.dbg_req_addr_in;
         r_data      <= dbg.dbg_req_data_in;
         r_clear_idx <= '0;
      end else if (w_access && (r_op == OP_CLEAR)) begin
         r_clear_idx <= r_clear_idx + 1'b1;
      end
   end

   // Registered stall/response outputs; response data loads only when a response is due
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_stall     <= 1'b0;
         r_rsp_valid <= 1'b0;
         r_rsp_data  <= '0;
      end else begin
         r_stall     <= (w_next == ST_STALL);
         r_rsp_valid <= (w_next == ST_RESP);
         if (w_next == ST_RESP) begin
            case (r_op)
               OP_READ:  r_rsp_data <= rf_read_data2_in;
               OP_WRITE: r_rsp_data <= r_data;
               default:  r_rsp_data <= '0;
            endcase
         end
      end
   end

   assign core_stall_out        = r_stall;
   assign dbg.dbg_req_ready_out = (r_state == ST_IDLE);
   assign dbg.dbg_rsp_valid_out = r_rsp_valid;
   assign dbg.dbg_rsp_data_out  = r_rsp_data;

`ifdef RFARB_PERF_CNT_EN
   logic [31:0] r_dbg_access_cnt;
   logic [31:0] r_stall_cnt;

   // Saturating counters of completed debug requests and forced stall cycles
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_dbg_access_cnt <= '0;
         r_stall_cnt      <= '0;
      end else begin
         if ((r_state == ST_RESP) && (r_dbg_access_cnt != 32'hFFFF_FFFF)) begin
            r_dbg_access_cnt <= r_dbg_access_cnt + 32'd1;
         end
         if ((r_state == ST_STALL) && (r_stall_cnt != 32'hFFFF_FFFF)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
         end
      end
   end

   assign dbg_access_cnt_out = r_dbg_access_cnt;
   assign stall_cnt_out      = r_stall_cnt;
`endif

endmodule

// File: tb/tb_regfile_access_arbiter.sv
// Directed bench for regfile_access_arbiter with a small register file model.
module tb_regfile_access_arbiter;
   logic        clk;
   logic        rst_n;
   logic        coreWrEn;
   logic [4:0]  coreWrAddr;
   logic [31:0] coreWrData;
   logic        coreRd2Busy;
   logic [4:0]  coreRd2Addr;
   logic        coreStall;
   logic        rfWriteEn;
   logic [4:0]  rfWriteAddr;
   logic [31:0] rfWriteData;
   logic [4:0]  rfReadAddr2;
   logic [31:0] rfReadData2;
`ifdef RFARB_PERF_CNT_EN
   logic [31:0] dbgAccessCnt;
   logic [31:0] stallCnt;
`endif

   int checks;
   int failures;
   int xzrWrites;

   logic [31:0] rfMem [32];

   regfile_access_arbiter_if #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5)) dbgIf ();

   regfile_access_arbiter #(
      .DATA_WIDTH     (32),
      .REG_COUNT      (32),
      .REG_ADDR_WIDTH (5),
      .STARVE_LIMIT   (8)
   ) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .core_wr_en_in     (coreWrEn),
      .core_wr_addr_in   (coreWrAddr),
      .core_wr_data_in   (coreWrData),
      .core_rd2_busy_in  (coreRd2Busy),
      .core_rd2_addr_in  (coreRd2Addr),
      .core_stall_out    (coreStall),
      .dbg               (dbgIf),
`ifdef RFARB_PERF_CNT_EN
      .dbg_access_cnt_out(dbgAccessCnt),
      .stall_cnt_out     (stallCnt),
`endif
      .rf_write_en_out   (rfWriteEn),
      .rf_write_addr_out (rfWriteAddr),
      .rf_write_data_out (rfWriteData),
      .rf_read_addr2_out (rfReadAddr2),
      .rf_read_data2_in  (rfReadData2)
   );

   // Free-running clock, rising edges at 5, 15, 25 ...
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Register file model: preloaded with a recognisable pattern on reset, XZR never stored
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 32; i++) rfMem[i] <= 32'hA000_0000 | i;
      end else if (rfWriteEn && (rfWriteAddr != 5'd31)) begin
         rfMem[rfWriteAddr] <= rfWriteData;
      end
   end

   // Read port 2 with write bypass; XZR reads as zero
   always_comb begin
      rfReadData2 = rfMem[rfReadAddr2];
      if (rfReadAddr2 == 5'd31) begin
         rfReadData2 = '0;
      end else if (rfWriteEn && (rfWriteAddr == rfReadAddr2)) begin
         rfReadData2 = rfWriteData;
      end
   end

   // Any write-enable to XZR reaching the register file is an error
   initial xzrWrites = 0;
   always @(negedge clk) begin
      if (rst_n && rfWriteEn && (rfWriteAddr == 5'd31)) xzrWrites++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // One-cycle debug handshake from IDLE; returns settled in the cycle after accept
   task automatic applyStimulus(input logic [1:0] op, input logic [4:0] addr,
                                input logic [31:0] data);
      dbgIf.dbg_req_valid_in = 1'b1;
      dbgIf.dbg_req_op_in    = op;
      dbgIf.dbg_req_addr_in  = addr;
      dbgIf.dbg_req_data_in  = data;
      #1;
      checkOutput("accept_ready", dbgIf.dbg_req_ready_out, 1);
      tick();
      dbgIf.dbg_req_valid_in = 1'b0;
      #1;
   endtask

   initial begin
      checks = 0;
      failures = 0;
      rst_n = 1'b0;
      coreWrEn = 1'b0;
      coreWrAddr = '0;
      coreWrData = '0;
      coreRd2Busy = 1'b0;
      coreRd2Addr = '0;
      dbgIf.dbg_req_valid_in = 1'b0;
      dbgIf.dbg_req_op_in = 2'b00;
      dbgIf.dbg_req_addr_in = '0;
      dbgIf.dbg_req_data_in = '0;
      repeat (2) tick();

      // Reset state
      checkOutput("rst_stall", coreStall, 0);
      checkOutput("rst_rsp_valid", dbgIf.dbg_rsp_valid_out, 0);
      checkOutput("rst_rsp_data", dbgIf.dbg_rsp_data_out, 0);
      checkOutput("rst_rf_we", rfWriteEn, 0);
      rst_n = 1'b1;
      tick();
      checkOutput("rst_ready", dbgIf.dbg_req_ready_out, 1);

      // Debug write addr 3, then read it back, core idle
      applyStimulus(2'b01, 5'd3, 32'hDEAD_BEEF);
      checkOutput("wr_access_en", rfWriteEn, 1);
      checkOutput("wr_access_addr", rfWriteAddr, 3);
      checkOutput("wr_access_data", rfWriteData, 32'hDEAD_BEEF);
      checkOutput("wr_busy_ready", dbgIf.dbg_req_ready_out, 0);
      checkOutput("wr_early_rsp", dbgIf.dbg_rsp_valid_out, 0);
      tick();
      checkOutput("wr_rsp_valid", dbgIf.dbg_rsp_valid_out, 1);
      checkOutput("wr_rsp_data", dbgIf.dbg_rsp_data_out, 32'hDEAD_BEEF);
      tick();
      checkOutput("wr_rsp_pulse", dbgIf.dbg_rsp_valid_out, 0);
      checkOutput("wr_rsp_hold", dbgIf.dbg_rsp_data_out, 32'hDEAD_BEEF);
      checkOutput("wr_back_ready", dbgIf.dbg_req_ready_out, 1);
      applyStimulus(2'b00, 5'd3, 32'h0);
      checkOutput("rd_access_addr", rfReadAddr2, 3);
      checkOutput("rd_access_we", rfWriteEn, 0);
      tick();
      checkOutput("rd_rsp_valid", dbgIf.dbg_rsp_valid_out, 1);
      checkOutput("rd_rsp_data", dbgIf.dbg_rsp_data_out, 32'hDEAD_BEEF);
      tick();

      // Debug write to XZR is acknowledged but never reaches the register file
      applyStimulus(2'b01, 5'd31, 32'h5);
      checkOutput("xzr_access_we", rfWriteEn, 0);
      tick();
      checkOutput("xzr_rsp_valid", dbgIf.dbg_rsp_valid_out, 1);
      checkOutput("xzr_rsp_data", dbgIf.dbg_rsp_data_out, 32'h5);
      tick();
      applyStimulus(2'b00, 5'd31, 32'h0);
      tick();
      checkOutput("xzr_rd_valid", dbgIf.dbg_rsp_valid_out, 1);
      checkOutput("xzr_rd_data", dbgIf.dbg_rsp_data_out, 32'h0);
      tick();

      // Core write held high: starvation forces one stall cycle 9 cycles after accept
      coreWrEn = 1'b1;
      coreWrAddr = 5'd7;
      coreWrData = 32'h77;
      #1;
      checkOutput("core_fwd_idle", rfWriteAddr, 7);
      applyStimulus(2'b00, 5'd5, 32'h0);
      for (int k = 1; k <= 8; k++) begin
         checkOutput("starve_no_stall", coreStall, 0);
         checkOutput("starve_core_fwd", rfWriteEn, 1);
         checkOutput("starve_no_rsp", dbgIf.dbg_rsp_valid_out, 0);
         tick();
      end
      checkOutput("stall_high", coreStall, 1);
      checkOutput("stall_core_blocked", rfWriteEn, 0);
      checkOutput("stall_rd_addr", rfReadAddr2, 5);
      tick();
      checkOutput("stall_one_cycle", coreStall, 0);
      checkOutput("stall_rsp_valid", dbgIf.dbg_rsp_valid_out, 1);
      checkOutput("stall_rsp_data", dbgIf.dbg_rsp_data_out, 32'hA000_0005);
      coreWrEn = 1'b0;
      tick();

      // Clear-all delayed by 3 core writes, then reset part way through
      coreWrEn = 1'b1;
      coreWrAddr = 5'd9;
      coreWrData = 32'h99;
      applyStimulus(2'b10, 5'd0, 32'h0);
      for (int k = 0; k < 3; k++) begin
         checkOutput("clr_core_addr", rfWriteAddr, 9);
         checkOutput("clr_core_data", rfWriteData, 32'h99);
         tick();
      end
      coreWrEn = 1'b0;
      #1;
      for (int k = 0; k < 10; k++) begin
         checkOutput("clr_intl_en", rfWriteEn, 1);
         checkOutput("clr_intl_addr", rfWriteAddr, k);
         checkOutput("clr_intl_data", rfWriteData, 0);
         tick();
      end
      rst_n = 1'b0;
      #1;
      checkOutput("midrst_stall", coreStall, 0);
      checkOutput("midrst_rsp_valid", dbgIf.dbg_rsp_valid_out, 0);
      checkOutput("midrst_rsp_data", dbgIf.dbg_rsp_data_out, 0);
      checkOutput("midrst_rf_we", rfWriteEn, 0);
      tick();
      rst_n = 1'b1;
      tick();
      checkOutput("midrst_ready", dbgIf.dbg_req_ready_out, 1);
      checkOutput("midrst_no_rsp", dbgIf.dbg_rsp_valid_out, 0);
      checkOutput("midrst_no_write", rfWriteEn, 0);

      // Full clear-all with idle core: addresses 0..30 then a single zero response
      applyStimulus(2'b10, 5'd0, 32'h0);
      for (int k = 0; k < 31; k++) begin
         checkOutput("clr_en", rfWriteEn, 1);
         checkOutput("clr_addr", rfWriteAddr, k);
         checkOutput("clr_no_rsp", dbgIf.dbg_rsp_valid_out, 0);
         tick();
      end
      checkOutput("clr_rsp_valid", dbgIf.dbg_rsp_valid_out, 1);
      checkOutput("clr_rsp_data", dbgIf.dbg_rsp_data_out, 0);
      checkOutput("clr_done_we", rfWriteEn, 0);
      tick();
      applyStimulus(2'b00, 5'd4, 32'h0);
      tick();
      checkOutput("clr_rd4_data", dbgIf.dbg_rsp_data_out, 0);
      tick();

      // Core write to addr 2 in the access cycle defers the debug read
      applyStimulus(2'b00, 5'd2, 32'h0);
      coreWrEn = 1'b1;
      coreWrAddr = 5'd2;
      coreWrData = 32'h2222_2222;
      #1;
      checkOutput("defer_core_data", rfWriteData, 32'h2222_2222);
      checkOutput("defer_core_en", rfWriteEn, 1);
      tick();
      coreWrEn = 1'b0;
      #1;
      checkOutput("defer_no_rsp", dbgIf.dbg_rsp_valid_out, 0);
      checkOutput("defer_rd_addr", rfReadAddr2, 2);
      tick();
      checkOutput("defer_rsp_valid", dbgIf.dbg_rsp_valid_out, 1);
      checkOutput("defer_rsp_data", dbgIf.dbg_rsp_data_out, 32'h2222_2222);
      tick();

      // Core write to addr 2 in the accept cycle: read sees the new value
      coreWrEn = 1'b1;
      coreWrData = 32'h3333_3333;
      dbgIf.dbg_req_valid_in = 1'b1;
      dbgIf.dbg_req_op_in = 2'b00;
      dbgIf.dbg_req_addr_in = 5'd2;
      #1;
      checkOutput("accw_ready", dbgIf.dbg_req_ready_out, 1);
      tick();
      dbgIf.dbg_req_valid_in = 1'b0;
      coreWrEn = 1'b0;
      #1;
      checkOutput("accw_rd_addr", rfReadAddr2, 2);
      tick();
      checkOutput("accw_rsp_valid", dbgIf.dbg_rsp_valid_out, 1);
      checkOutput("accw_rsp_data", dbgIf.dbg_rsp_data_out, 32'h3333_3333);
      tick();

      // Read port 2 busy blocks a debug read but not a debug write
      coreRd2Busy = 1'b1;
      coreRd2Addr = 5'd12;
      applyStimulus(2'b01, 5'd6, 32'h66);
      checkOutput("busy_wr_en", rfWriteEn, 1);
      checkOutput("busy_wr_addr", rfWriteAddr, 6);
      tick();
      checkOutput("busy_wr_rsp", dbgIf.dbg_rsp_valid_out, 1);
      tick();
      applyStimulus(2'b11, 5'd6, 32'h0);
      checkOutput("busy_rd_core_addr", rfReadAddr2, 12);
      coreRd2Busy = 1'b0;
      #1;
      checkOutput("busy_rd_dbg_addr", rfReadAddr2, 6);
      tick();
      checkOutput("busy_rd_rsp", dbgIf.dbg_rsp_valid_out, 1);
      checkOutput("busy_rd_data", dbgIf.dbg_rsp_data_out, 32'h66);
      tick();

      checkOutput("xzr_never_written", xzrWrites, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/regfile_access_arbiter.md
Name: regfile_access_arbiter

Overview:
- Shares the register file's single write port and read port 2 between two requesters: the multicycle core and the UART debug host.
- The core has priority. Debug requests are accepted through a valid/ready handshake and serviced in free slots.
- A starvation timer forces a one-cycle core stall so a waiting debug access can complete.
- Also sequences a debug "clear-all" that zeroes every writable register.

Parameters:
DATA_WIDTH, 32, register data width
REG_COUNT, 32, number of registers; XZR = REG_COUNT-1
REG_ADDR_WIDTH, 5, register address width
STARVE_LIMIT, 8, blocked cycles before core stall is forced (legal range 1..255)

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
core_wr_en_in  in  1  core writeback request this cycle
core_wr_addr_in  in  REG_ADDR_WIDTH  core write address
core_wr_data_in  in  DATA_WIDTH  core write data
core_rd2_busy_in  in  1  core uses read port 2 this cycle
core_rd2_addr_in  in  REG_ADDR_WIDTH  core read-port-2 address
core_stall_out  out  1  registered; core gates its enables while high
dbg_req_valid_in  in  1  debug request valid
dbg_req_ready_out  out  1  debug request ready
dbg_req_op_in  in  2  00 read, 01 write, 10 clear-all, 11 reserved (treated as read)
dbg_req_addr_in  in  REG_ADDR_WIDTH  debug address
dbg_req_data_in  in  DATA_WIDTH  debug write data
dbg_rsp_valid_out  out  1  one-cycle completion pulse
dbg_rsp_data_out  out  DATA_WIDTH  read data / written data / 0 for clear-all
rf_write_en_out  out  1  to register file
rf_write_addr_out  out  REG_ADDR_WIDTH  to register file
rf_write_data_out  out  DATA_WIDTH  to register file
rf_read_addr2_out  out  REG_ADDR_WIDTH  to register file
rf_read_data2_in  in  DATA_WIDTH  from register file

Behaviour:
- Reset (rst_n low, any time): all registered outputs are 0 and the state is IDLE. Any pending request is dropped without a response.
- States:
  - IDLE: dbg_req_ready_out=1. On valid&ready, latch op/addr/data and go to PEND (op read/write) or CLEAR (clear_idx=0).
  - PEND: the slot is free when no core write is present and, for reads, the core is not using read port 2.
    - Free: perform the access, go to RESP.
    - Blocked: increment wait_cnt. When wait_cnt reaches STARVE_LIMIT, go to STALL.
  - STALL: core_stall_out=1 for exactly this cycle. Core inputs are ignored. The debug access is performed; go to RESP (or stay in CLEAR).
  - RESP: dbg_rsp_valid_out=1 for one cycle, wait_cnt=0, return to IDLE. dbg_req_ready_out=0 in every state except IDLE.
  - CLEAR: each free (or STALL) cycle writes 0 to clear_idx and increments it. wait_cnt clears after each write. After writing REG_COUNT-2, go to RESP with data 0.
- Datapath muxing (combinational):
  - Debug access cycle: rf_write_* / rf_read_addr2_out carry the debug values.
  - Otherwise: core values pass through unchanged. rf_write_en_out mirrors core_wr_en_in.
- Debug read: rf_read_data2_in is captured in the access cycle and driven on dbg_rsp_data_out with the RESP pulse. The captured value includes the register file's write bypass.
- Debug write to XZR: handshake and ack occur normally, but rf_write_en_out stays 0.
- Minimum latency: accept at cycle N, access at N+1, rsp_valid at N+2.
- A core write arriving in the accept cycle does not block the accept.
- dbg_rsp_data_out holds its value until the next response.

Optional Feature:
- Macro: RFARB_PERF_CNT_EN.
- When defined: adds outputs dbg_access_cnt_out[31:0] (completed debug requests) and stall_cnt_out[31:0] (cycles in STALL). Both saturate at all-ones and reset to 0.
- When undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package regfile_arb_pkg contains:
  - dbg_op_e enum (READ, WRITE, CLEAR)
  - arb_state_e enum (IDLE, PEND, CLEAR, STALL, RESP)
  - function xzr_addr(REG_COUNT, REG_ADDR_WIDTH)
- Sub-module rfarb_starve_timer holds wait_cnt. Ports: inc, clr, limit_hit.

Test Plan:
- Idle core; debug write addr 3 data 0xDEADBEEF, then read addr 3 -> write ack at N+2; read rsp_valid at N+2 with data 0xDEADBEEF.
- Debug write addr 31 data 0x5 -> ack pulses, rf_write_en_out never asserted; a later read of 31 returns 0.
- core_wr_en_in held high, STARVE_LIMIT=8, debug read pending -> core_stall_out high exactly one cycle, 9 cycles after accept. Read completes in that cycle; the core write is not forwarded during STALL.
- Clear-all with core idle -> 31 consecutive writes of 0 to addresses 0..30, then one rsp_valid with data 0. Interleaved core writes delay the sequence but never collide.
- Debug read addr 2 while core writes addr 2 in the access cycle (slot free path not taken) -> access deferred. Separately, a core write to addr 2 in the accept cycle -> the read returns the newly written value.
- Assert rst_n low mid-CLEAR -> all outputs 0 immediately, no rsp_valid, dbg_req_ready_out=1 after release.
